sys_reservation_station: RTL

SYS_RESERVATION_STATION -- requirements
Module: sys_reservation_station

---
 rtl/ppc_types.sv | 34 +++
 rtl/sys_reservation_station.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ppc_types.sv
// Shared PowerPC core types: decoded system operations and the reservation-station entry
// layout that the other reservation stations reuse.
package ppc_types;

    typedef enum logic [2:0] {
        SYS_NOP           = 3'd0,
        SYS_MOVE_TO_SPR   = 3'd1,
        SYS_MOVE_FROM_SPR = 3'd2,
        SYS_MOVE_TO_MSR   = 3'd3,
        SYS_MOVE_FROM_MSR = 3'd4,
        SYS_SYNC          = 3'd5,
        SYS_TRAP          = 3'd6
    } sys_op_e;

    typedef struct packed {
        sys_op_e    op;
        logic [9:0] spr;
    } system_decode_t;

    // Tag fields are stored at the core-wide tag width; stations may use fewer bits.
    localparam int PPC_RS_ID_WIDTH = 5;
    typedef logic [PPC_RS_ID_WIDTH-1:0] rs_tag_t;

    typedef struct packed {
        logic           valid;
        rs_tag_t        rs_id;
        logic [4:0]     result_reg_addr;
        system_decode_t control;
        logic           op1_ready;
        rs_tag_t        op1_tag;
        logic [31:0]    op1_value;
    } sys_rs_entry_t;

endpackage

// File: rtl/sys_reservation_station.sv
// In-order reservation station for the serializing system unit: a DEPTH-entry FIFO whose
// single operand is woken up by CDB broadcasts; only the head may issue.
module sys_reservation_station
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [4:0]             result_reg_addr_in,
    input  system_decode_t         control_in,
    input  logic                   op1_valid_in,
    input  logic [31:0]            op1_value_in,
    input  logic [RS_ID_WIDTH-1:0] op1_tag_in,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_result,
    input  logic                   flush,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [31:0]            op1_out,
    output system_decode_t         control_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sys_rs_entry_t    entries_q [DEPTH];
    sys_rs_entry_t    entries_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    rs_tag_t       cdb_tag;
    rs_tag_t       op1_tag_pad;
    rs_tag_t       rs_id_pad;
    sys_rs_entry_t new_entry;
    logic          do_dispatch;
    logic          do_issue;

    // Narrower station tags are zero-extended into the shared entry tag field.
    always_comb begin
        cdb_tag                       = '0;
        cdb_tag[RS_ID_WIDTH-1:0]      = cdb_rs_id;
        op1_tag_pad                   = '0;
        op1_tag_pad[RS_ID_WIDTH-1:0]  = op1_tag_in;
        rs_id_pad                     = '0;
        rs_id_pad[RS_ID_WIDTH-1:0]    = rs_id_in;
    end

    assign dispatch_ready      = (count_q < CNT_W'(DEPTH));
    assign output_valid        = entries_q[rd_ptr_q].valid & entries_q[rd_ptr_q].op1_ready;
    assign rs_id_out           = entries_q[rd_ptr_q].rs_id[RS_ID_WIDTH-1:0];
    assign result_reg_addr_out = entries_q[rd_ptr_q].result_reg_addr;
    assign op1_out             = entries_q[rd_ptr_q].op1_value;
    assign control_out         = entries_q[rd_ptr_q].control;

    assign do_dispatch = dispatch_valid & dispatch_ready;
    assign do_issue    = output_valid & output_ready;

    // The CDB is also checked against the incoming operand so a same-cycle broadcast is not lost.
    always_comb begin
        new_entry                 = '0;
        new_entry.valid           = 1'b1;
        new_entry.rs_id           = rs_id_pad;
        new_entry.result_reg_addr = result_reg_addr_in;
        new_entry.control         = control_in;
        new_entry.op1_tag         = op1_tag_pad;
        if (op1_valid_in) begin
            new_entry.op1_ready = 1'b1;
            new_entry.op1_value = op1_value_in;
        end else if (cdb_valid && (cdb_tag == op1_tag_pad)) begin
            new_entry.op1_ready = 1'b1;
            new_entry.op1_value = cdb_result;
        end else begin
            new_entry.op1_ready = 1'b0;
            new_entry.op1_value = op1_value_in;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (cdb_valid && entries_q[i].valid && !entries_q[i].op1_ready &&
                (entries_q[i].op1_tag == cdb_tag)) begin
                entries_d[i].op1_ready = 1'b1;
                entries_d[i].op1_value = cdb_result;
            end
        end
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        // Dispatch only happens below DEPTH entries, so it never lands on a still-valid head.
        if (do_issue) begin
            entries_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d                  = rd_ptr_q + 1'b1;
        end
        if (do_dispatch) begin
            entries_d[wr_ptr_q] = new_entry;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        case ({do_dispatch, do_issue})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid     = 1'b0;
                entries_d[i].op1_ready = 1'b0;
            end
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entries_q[gi] <= '0;
                end else begin
                    entries_q[gi] <= entries_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
